permutation_ctrl: RTL and testbench
===================================

PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

Interface
REQ-001 The module SHALL have port clock_i, input, 1 bit: single clock, all logic on its rising edge.
REQ-002 The module SHALL have port resetb_i, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have port start_i, input, 1 bit: request one permutation run.
REQ-004 The module SHALL have port mode_i, input, 1 bit: 0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11).
REQ-005 The module SHALL have port round_o, output, 4 bits: round index driven to the constant-addition stage.
REQ-006 The module SHALL have port sel_state_o, output, 1 bit: 0 = datapath takes the external state, 1 = datapath takes the registered feedback state.
REQ-007 The module SHALL have port en_state_o, output, 1 bit: state register write enable.
REQ-008 The module SHALL have port busy_o, output, 1 bit: high while a run is in progress.
REQ-009 The module SHALL have port done_o, output, 1 bit: one-cycle pulse when the final round is registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start_i = 1 SHALL be accepted at the clock edge; mode_i SHALL be latched at that edge and the FSM SHALL move to RUN.
REQ-012 In RUN, start_i and mode_i SHALL be ignored; mode changes during a run SHALL have no effect.
REQ-013 On acceptance, the round counter SHALL load 0 for p12 and 6 for p6.
REQ-014 In RUN, round_o SHALL equal the counter, en_state_o SHALL be 1 and busy_o SHALL be 1.
REQ-015 sel_state_o SHALL be 0 in the first RUN cycle only and 1 in every later RUN cycle.
REQ-016 In RUN, the counter SHALL increment by 1 per cycle while below 11.
REQ-017 In RUN with counter = 11, the next state SHALL be DONE.
REQ-018 The counter SHALL never present the values 12..15, and no wrap-around SHALL occur.
REQ-019 Latency: for start accepted at edge k, RUN SHALL occupy cycles k+1..k+12 (p12) or k+1..k+6 (p6), and done_o SHALL be 1 in cycle k+13 or k+7 respectively.
REQ-020 In DONE, done_o SHALL be 1, busy_o = 0, en_state_o = 0 and round_o = 0.
REQ-021 In DONE, the next state SHALL be IDLE if start_i = 0, or RUN if start_i = 1 (back-to-back run with no idle cycle).
REQ-022 In IDLE, all outputs SHALL be 0.
REQ-023 All outputs SHALL be registered or decoded from registered state only, with no combinational path from start_i.

Reset
REQ-024 resetb_i = 0 at a clock edge SHALL force IDLE, counter = 0, latched mode = 0 and all outputs = 0, overriding start_i.
REQ-025 Reset asserted during RUN SHALL abort the run with no done_o pulse.
REQ-026 After reset release, the first start_i edge SHALL be accepted normally.

Configuration
REQ-027 With macro PERM_CTRL_ABORT_EN defined, an input port abort_i (1 bit) SHALL exist.
REQ-028 With PERM_CTRL_ABORT_EN defined, abort_i = 1 in RUN SHALL force IDLE at the next edge: counter 0, no done_o pulse, en_state_o = 0 from the next cycle.
REQ-029 With PERM_CTRL_ABORT_EN defined, abort_i SHALL have priority over start_i and be ignored outside RUN.
REQ-030 Without PERM_CTRL_ABORT_EN, the port SHALL be absent and a run SHALL end only by completion or reset.

Verification
REQ-031 Bench SHALL check p12: mode_i = 0, start pulse at edge k -> round_o = 0,1,...,11 over cycles k+1..k+12; sel_state_o = 0 then 1; done_o = 1 only in cycle k+13.
REQ-032 Bench SHALL check p6: mode_i = 1 -> round_o = 6..11 over 6 cycles; done_o at k+7; busy_o high for exactly 6 cycles.
REQ-033 Bench SHALL check ignored inputs: start_i held 1 and mode_i toggled during RUN -> sequence unchanged; with start_i still 1 in DONE, a new run starts with round_o = first round at cycle k+14.
REQ-034 Bench SHALL check reset mid-run: resetb_i = 0 at round 5 -> next cycle all outputs 0 and state IDLE; no done_o pulse; a later start runs a full p12.
REQ-035 Bench SHALL check abort (PERM_CTRL_ABORT_EN): abort_i = 1 at round 3 -> IDLE next cycle, done_o never 1; abort_i = 1 in IDLE -> no effect.
REQ-036 Bench SHALL check full-datapath integration: p12 from the initial ASCON state {00001000808C0001, 6CB10AD9CA912F80, 691AED630E81901F, 0C4C36A20853217C, 46487B3E06D9D7A8} -> final state equals the golden value from the ASCON-128 specification.

Source files
------------

// File: rtl/permutation_ctrl.sv
// Round sequencer for an ASCON-style permutation: runs p12 (rounds 0..11) or p6 (rounds 6..11).
// Optional macro PERM_CTRL_ABORT_EN adds abort_i, which cancels a run in progress.
module permutation_ctrl (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
`ifdef PERM_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic [3:0] round_o,
  output logic       sel_state_o,
  output logic       en_state_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     state;
  logic [3:0] cnt;
  logic       mode_lat;
  logic       abort_s;

  function automatic logic [3:0] first_round(input logic mode);
    return mode ? 4'd6 : 4'd0;
  endfunction

`ifdef PERM_CTRL_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // Sequencer state, round counter and all outputs are registered together.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      mode_lat    <= 1'b0;
      round_o     <= 4'd0;
      sel_state_o <= 1'b0;
      en_state_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state       <= RUN;
            cnt         <= first_round(mode_i);
            mode_lat    <= mode_i;
            round_o     <= first_round(mode_i);
            sel_state_o <= 1'b0;
            en_state_o  <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
          end else begin
            state       <= IDLE;
            cnt         <= 4'd0;
            round_o     <= 4'd0;
            sel_state_o <= 1'b0;
            en_state_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
          end
        end
        RUN: begin
          // A counter outside the window of the latched mode cannot occur legally; treat it like an abort.
          if (abort_s || (cnt < first_round(mode_lat)) || (cnt > LAST_ROUND)) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            round_o     <= 4'd0;
            sel_state_o <= 1'b0;
            en_state_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
          end else if (cnt == LAST_ROUND) begin
            state       <= DONE;
            cnt         <= 4'd0;
            round_o     <= 4'd0;
            sel_state_o <= 1'b0;
            en_state_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            state       <= RUN;
            cnt         <= cnt + 4'd1;
            round_o     <= cnt + 4'd1;
            sel_state_o <= 1'b1;
            en_state_o  <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= 4'd0;
          mode_lat    <= 1'b0;
          round_o     <= 4'd0;
          sel_state_o <= 1'b0;
          en_state_o  <= 1'b0;
          busy_o      <= 1'b0;
          done_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: queue-based round model plus an ASCON datapath driven by the controller.
module tb_permutation_ctrl;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [3:0] round_o;
  logic       sel_state_o, en_state_o, busy_o, done_o;

  permutation_ctrl dut (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
`ifdef PERM_CTRL_ABORT_EN
    .abort_i     (abort_i),
`endif
    .round_o     (round_o),
    .sel_state_o (sel_state_o),
    .en_state_o  (en_state_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic       busy;
    logic       done;
  } outs_t;

  localparam int DONE_MARK = 99;
  localparam logic [319:0] ASCON_INIT = {64'h00001000808C0001, 64'h6CB10AD9CA912F80,
                                         64'h691AED630E81901F, 64'h0C4C36A20853217C,
                                         64'h46487B3E06D9D7A8};

  outs_t exp_q[$];
  string lbl_q[$];
  int    pend[$];
  bit    fresh = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  string phase = "reset";

  logic [319:0] dp = '0;
  logic [319:0] ref_state;
  bit           dp_armed = 1'b0;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ {56'd0, 4'hF - r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Datapath stand-in: state register steered by the controller's mux select and write enable.
  always @(posedge clock_i) begin
    if (en_state_o) dp <= ascon_round(sel_state_o ? dp : ASCON_INIT, round_o);
  end

  // Reference model: a run is a queue of pending rounds followed by a done marker.
  function automatic void step_model(input bit start, input bit mode, input bit rstb,
                                     input bit abort, output outs_t e);
    if (!rstb) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0] != DONE_MARK) begin
      if (abort) pend.delete();
      else begin
        void'(pend.pop_front());
        fresh = 1'b0;
      end
    end else begin
      if (pend.size() > 0) void'(pend.pop_front());
      if (start) begin
        for (int r = (mode ? 6 : 0); r <= 11; r++) pend.push_back(r);
        pend.push_back(DONE_MARK);
        fresh = 1'b1;
      end
    end
    e = '0;
    if (pend.size() > 0) begin
      if (pend[0] == DONE_MARK) e.done = 1'b1;
      else begin
        e.round = 4'(pend[0]);
        e.en    = 1'b1;
        e.busy  = 1'b1;
        e.sel   = !fresh;
      end
    end
  endfunction

  task automatic drive(input bit start, input bit mode, input bit rstb, input bit abort);
    outs_t e;
    bit    ab;
    @(posedge clock_i);
    #2;
    start_i  = start;
    mode_i   = mode;
    resetb_i = rstb;
`ifdef PERM_CTRL_ABORT_EN
    abort_i = abort;
    ab      = abort;
`else
    abort_i = 1'b0;
    ab      = 1'b0;
`endif
    step_model(start, mode, rstb, ab, e);
    exp_q.push_back(e);
    lbl_q.push_back(phase);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  outs_t mon_e, mon_g;
  string mon_l;

  // Monitor: one expectation per cycle, sampled just after the active edge.
  always @(posedge clock_i) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_l = lbl_q.pop_front();
      mon_g = {round_o, sel_state_o, en_state_o, busy_o, done_o};
      n_checks++;
      if (mon_g !== mon_e) begin
        n_fail++;
        $display("FAIL %s @%0t: got round=%0d sel=%b en=%b busy=%b done=%b, expected round=%0d sel=%b en=%b busy=%b done=%b",
                 mon_l, $time, mon_g.round, mon_g.sel, mon_g.en, mon_g.busy, mon_g.done,
                 mon_e.round, mon_e.sel, mon_e.en, mon_e.busy, mon_e.done);
      end
      if (dp_armed && done_o === 1'b1) begin
        dp_armed = 1'b0;
        n_checks++;
        if (dp !== ref_state) begin
          n_fail++;
          $display("FAIL datapath_p12: got %h, expected %h", dp, ref_state);
        end
      end
    end
  end

  initial begin
    ref_state = ASCON_INIT;
    for (int r = 0; r < 12; r++) ref_state = ascon_round(ref_state, 4'(r));

    phase = "reset_overrides_start";
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    phase = "idle";
    idle_cycles(2);

    phase = "p12_datapath";
    dp_armed = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(15);
    n_checks++;
    if (dp_armed) begin
      n_fail++;
      $display("FAIL datapath_done_timeout: got no done_o pulse, expected one within 13 cycles");
      dp_armed = 1'b0;
    end

    phase = "p6";
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(9);

    phase = "start_held_mode_toggled";
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) drive(1'b1, 1'(i & 1), 1'b1, 1'b0);
    idle_cycles(15);

    phase = "reset_mid_run";
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);
    phase = "p12_after_reset";
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(15);

`ifdef PERM_CTRL_ABORT_EN
    phase = "abort_round3";
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    idle_cycles(3);
    phase = "abort_in_idle";
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    idle_cycles(9);
`endif

    phase = "random";
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 59) != 0), ($urandom_range(0, 19) == 0));

    phase = "drain";
    idle_cycles(15);
    @(posedge clock_i);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
